// File: rtl/axi4_burst_regbank.sv
// AXI4 slave register bank with FIXED/INCR/WRAP bursts, byte strobes and per-transaction errors.
// Independent write and read FSMs, each with one outstanding transaction.
module axi4_burst_regbank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                    i_aclk,
    input  logic                    i_aresetn,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int BPW     = int'(DATA_WIDTH / 8);
    localparam int SizeMax = $clog2(BPW);
    localparam int IdxW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] RangeBytes = (ADDR_WIDTH + 1)'(DEPTH * DATA_WIDTH / 8);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] sum;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        sum  = addr + (ADDR_WIDTH'(1) << size);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (sum & mask);
            default: return sum;
        endcase
    endfunction

    function automatic logic f_txn_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [11:0] align;
        logic [16:0] last;
        logic        err;
        align = ~((12'd1 << size) - 12'd1);
        // End of burst measured from the size-aligned start, within its 4KB page.
        last  = {5'd0, addr[11:0] & align} + (({9'd0, len} + 17'd1) << size);
        err   = 1'b0;
        if (size > 3'(SizeMax)) err = 1'b1;
        if (burst == 2'b11) err = 1'b1;
        if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            err = 1'b1;
        if (burst == 2'b10 && (addr[11:0] & ~align) != 12'd0) err = 1'b1;
        if (burst == 2'b01 && last > 17'd4096) err = 1'b1;
        return err;
    endfunction

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, addr} - {1'b0, START_ADDR};
        return !off[ADDR_WIDTH] && (off < RangeBytes);
    endfunction

    function automatic logic [IdxW-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - START_ADDR;
        return off[SizeMax +: IdxW];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    w_state_e              r_wstate;
    logic [ID_WIDTH-1:0]   r_wid;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic                  r_wslverr;
    logic                  r_wdecerr;
    logic                  r_wlasterr;

    r_state_e              r_rstate;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic                  r_rslverr;

    logic                  w_win_range;
    logic                  w_wlast_beat;
    logic                  w_wlast_bad;
    logic [1:0]            w_bresp;
    logic                  w_ar_err;
    logic [ADDR_WIDTH-1:0] w_ld_addr;
    logic                  w_ld_err;
    logic                  w_ld_inr;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [1:0]            w_ld_resp;

    assign w_win_range  = f_in_range(r_waddr);
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wlast_bad  = (i_wlast != w_wlast_beat);
    assign w_bresp      = r_wslverr                    ? 2'b10 :
                          (r_wdecerr || !w_win_range)  ? 2'b11 :
                          (r_wlasterr || w_wlast_bad)  ? 2'b10 : 2'b00;

    assign w_ar_err  = f_txn_err(i_araddr, i_arlen, i_arsize, i_arburst);
    // Beat 0 loads from the AR channel; later beats from the advanced latched address.
    assign w_ld_addr = (r_rstate == RIdle) ? i_araddr : r_raddr;
    assign w_ld_err  = (r_rstate == RIdle) ? w_ar_err : r_rslverr;
    assign w_ld_inr  = f_in_range(w_ld_addr);
    assign w_ld_data = (w_ld_err || !w_ld_inr) ? '0 : r_mem[f_idx(w_ld_addr)];
    assign w_ld_resp = w_ld_err ? 2'b10 : (!w_ld_inr ? 2'b11 : 2'b00);

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wstate   <= WIdle;
            o_awready  <= 1'b0;
            o_wready   <= 1'b0;
            o_bvalid   <= 1'b0;
            o_bid      <= '0;
            o_bresp    <= 2'b00;
            r_wid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wcnt     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_wslverr  <= 1'b0;
            r_wdecerr  <= 1'b0;
            r_wlasterr <= 1'b0;
        end else begin
            unique case (r_wstate)
                WIdle: begin
                    if (o_awready && i_awvalid) begin
                        r_wid      <= i_awid;
                        r_waddr    <= i_awaddr;
                        r_wlen     <= i_awlen;
                        r_wsize    <= i_awsize;
                        r_wburst   <= i_awburst;
                        r_wslverr  <= f_txn_err(i_awaddr, i_awlen, i_awsize, i_awburst);
                        r_wdecerr  <= 1'b0;
                        r_wlasterr <= 1'b0;
                        r_wcnt     <= '0;
                        o_awready  <= 1'b0;
                        o_wready   <= 1'b1;
                        r_wstate   <= WData;
                    end else begin
                        o_awready <= 1'b1;
                    end
                end
                WData: begin
                    if (i_wvalid && o_wready) begin
                        if (!r_wslverr && w_win_range) begin
                            for (int b = 0; b < BPW; b++) begin
                                if (i_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= i_wdata[8*b +: 8];
                            end
                        end
                        r_waddr    <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                        r_wcnt     <= r_wcnt + 8'd1;
                        r_wdecerr  <= r_wdecerr | !w_win_range;
                        r_wlasterr <= r_wlasterr | w_wlast_bad;
                        if (w_wlast_beat) begin
                            o_wready <= 1'b0;
                            o_bvalid <= 1'b1;
                            o_bid    <= r_wid;
                            o_bresp  <= w_bresp;
                            r_wstate <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (i_bready) begin
                        o_bvalid  <= 1'b0;
                        o_awready <= 1'b1;
                        r_wstate  <= WIdle;
                    end
                end
                default: r_wstate <= WIdle;
            endcase
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            r_rstate  <= RIdle;
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rid     <= '0;
            o_rdata   <= '0;
            o_rresp   <= 2'b00;
            o_rlast   <= 1'b0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rslverr <= 1'b0;
        end else begin
            unique case (r_rstate)
                RIdle: begin
                    if (o_arready && i_arvalid) begin
                        o_rid     <= i_arid;
                        r_rlen    <= i_arlen;
                        r_rsize   <= i_arsize;
                        r_rburst  <= i_arburst;
                        r_rslverr <= w_ar_err;
                        r_raddr   <= f_next_addr(i_araddr, i_arlen, i_arsize, i_arburst);
                        r_rcnt    <= '0;
                        o_rdata   <= w_ld_data;
                        o_rresp   <= w_ld_resp;
                        o_rlast   <= (i_arlen == 8'd0);
                        o_rvalid  <= 1'b1;
                        o_arready <= 1'b0;
                        r_rstate  <= RData;
                    end else begin
                        o_arready <= 1'b1;
                    end
                end
                RData: begin
                    if (o_rvalid && i_rready) begin
                        if (o_rlast) begin
                            o_rvalid  <= 1'b0;
                            o_arready <= 1'b1;
                            r_rstate  <= RIdle;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
                            o_rdata <= w_ld_data;
                            o_rresp <= w_ld_resp;
                            o_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= RIdle;
            endcase
        end
    end

endmodule
